fetch_ifid: RTL and testbench
=============================

Name: fetch_ifid

Overview:
- Fetch stage plus IF/ID pipeline register, sitting directly upstream of decode.
- Holds the PC and issues requests to a variable-latency instruction memory.
- Presents instruction, currPC and new_addr (PC+2) to decode.
- Consumes decode's stall, flush/nextPC and HALT; squashes wrong-path fetches and stops fetching on HALT.

Parameters:
- RESET_PC, 16'h0000, PC value loaded at reset.
- NOP_INSTR, 16'h0800, bubble instruction placed in IF/ID on reset, flush and halt.

Ports:
- clk  input  1  single clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset (0 = reset)
- stall  input  1  hazard stall; hold IF/ID and PC
- flush  input  1  redirect from decode; squash IF/ID
- nextPC  input  16  redirect target, valid when flush=1
- halt_dec  input  1  decode's HALT for the IF/ID instruction
- imem_data  input  16  instruction word from memory
- imem_done  input  1  imem_data valid this cycle
- imem_rd  output  1  read request
- imem_addr  output  16  read address; stable while imem_rd=1 and imem_done=0
- instruction  output  16  IF/ID instruction
- currPC  output  16  IF/ID instruction address
- new_addr  output  16  IF/ID PC+2
- valid_id  output  1  IF/ID holds a real instruction
- fetch_busy  output  1  request outstanding and not done
- err  output  1  sticky misaligned-PC error

Behaviour:

Reset (rst=0, async):
- PC=RESET_PC; state=FETCH.
- instruction=NOP_INSTR; currPC=RESET_PC; new_addr=RESET_PC+2; valid_id=0.
- imem_rd=0; err=0; hold buffer empty.
- First request is issued in the first cycle after rst rises.

States: FETCH, HOLD, DRAIN, HALTED.

FETCH:
- Drive imem_rd=1 and imem_addr=PC.
- On imem_done & !stall:
  - IF/ID <= {imem_data, PC, PC+2}; valid_id=1; PC<=PC+2.
- On imem_done & stall:
  - Capture imem_data into the hold buffer; PC<=PC+2; go to HOLD.
- With a single-cycle memory (done in the same cycle as rd), throughput is 1 instruction/cycle and load latency is 1 cycle.

HOLD:
- imem_rd=0.
- When stall drops, load the hold buffer into IF/ID (with the captured PC and PC+2), then return to FETCH.

Stall:
- IF/ID outputs are unchanged while stall=1.

Flush (priority over stall and halt):
- IF/ID <= {NOP_INSTR, nextPC, nextPC+2}; valid_id=0; PC<=nextPC.
- Hold buffer is discarded.
- If a request is outstanding (imem_rd=1, imem_done=0): go to DRAIN. imem_rd and imem_addr stay at the old address until done; the returned data is dropped; then go to FETCH at the new PC.
- If done arrives in the flush cycle, its data is dropped and the next state is FETCH.

Halt (halt_dec & valid_id & !stall & !flush):
- IF/ID <= NOP_INSTR; valid_id=0; go to HALTED.
- An outstanding request is drained (data dropped) before imem_rd falls.
- HALTED: imem_rd=0, PC frozen, inputs ignored; exits only via reset.

Misaligned PC:
- nextPC[0]=1 on flush sets err=1 (sticky) and goes to HALTED (draining first if needed).

Arithmetic:
- PC+2 wraps modulo 2^16 (16'hFFFE -> 16'h0000).

fetch_busy:
- = imem_rd & !imem_done.

Reset mid-request:
- Aborts immediately; memory must tolerate imem_rd dropping.

Test Plan:
- Reset release, memory done every cycle, imem_data=0x1111,0x2222,0x3333 -> imem_addr 0,2,4; IF/ID currPC=0,2,4, new_addr=2,4,6, valid_id=1 from cycle 2.
- Memory latency 3 cycles -> imem_addr held at 0x0002 for 3 cycles, fetch_busy=1 for 2 cycles, IF/ID changes only on done.
- stall=1 for 2 cycles while done arrives with 0xABCD at PC 0x0010 -> IF/ID holds the previous instruction, then shows 0xABCD/0x0010/0x0012 one cycle after stall falls; no fetch is lost or duplicated.
- flush=1, nextPC=0x0040, with the request at 0x0008 outstanding 2 more cycles -> IF/ID=0x0800, valid_id=0; old data dropped; next imem_addr=0x0040.
- halt_dec=1 with valid_id=1 -> IF/ID=0x0800, imem_rd=0 thereafter; PC frozen over 10 cycles; rst pulse restarts at 0x0000.
- PC=0xFFFE fetch -> new_addr=0x0000, next imem_addr=0x0000; flush to 0x0033 -> err=1, HALTED.

Source files
------------

// File: rtl/fetch_ifid.sv
// Fetch stage plus IF/ID pipeline register feeding decode.
// Issues in-order requests to a variable-latency instruction memory; handles stall, redirect and HALT.
module fetch_ifid #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [15:0] nextPC,
    input  logic        halt_dec,
    input  logic [15:0] imem_data,
    input  logic        imem_done,
    output logic        imem_rd,
    output logic [15:0] imem_addr,
    output logic [15:0] instruction,
    output logic [15:0] currPC,
    output logic [15:0] new_addr,
    output logic        valid_id,
    output logic        fetch_busy,
    output logic        err
);

    typedef enum logic [1:0] {FETCH, HOLD, DRAIN, HALTED} state_t;

    state_t      state, state_nxt;
    logic [15:0] pc, pc_nxt;
    logic [15:0] drain_addr, drain_addr_nxt;
    logic        drain_halt, drain_halt_nxt;
    logic [15:0] hold_instr, hold_instr_nxt;
    logic [15:0] hold_pc, hold_pc_nxt;
    logic [15:0] instr_nxt, curr_pc_nxt, new_addr_nxt;
    logic        valid_nxt, err_nxt;
    logic        halt_take, accept_flush, misaligned;

    assign misaligned   = nextPC[0];
    assign halt_take    = halt_dec & valid_id & ~stall & ~flush;
    // A drain that ends in HALTED already belongs to a halted machine, so redirects are ignored there.
    assign accept_flush = flush & (state != HALTED) & ~((state == DRAIN) & drain_halt);

    assign imem_rd    = rst & ((state == FETCH) | (state == DRAIN));
    assign imem_addr  = (state == DRAIN) ? drain_addr : pc;
    assign fetch_busy = imem_rd & ~imem_done;

    always_comb begin
        // NOTE: every next-state value defaults to the current value, so no branch can infer a latch.
        state_nxt      = state;
        pc_nxt         = pc;
        drain_addr_nxt = drain_addr;
        drain_halt_nxt = drain_halt;
        hold_instr_nxt = hold_instr;
        hold_pc_nxt    = hold_pc;
        instr_nxt      = instruction;
        curr_pc_nxt    = currPC;
        new_addr_nxt   = new_addr;
        valid_nxt      = valid_id;
        err_nxt        = err;

        if (accept_flush) begin
            instr_nxt    = NOP_INSTR;
            curr_pc_nxt  = nextPC;
            new_addr_nxt = nextPC + 16'd2;
            valid_nxt    = 1'b0;
            pc_nxt       = nextPC;
            err_nxt      = err | misaligned;
            if (imem_rd & ~imem_done) begin
                state_nxt      = DRAIN;
                drain_halt_nxt = misaligned;
                if (state == FETCH) drain_addr_nxt = pc;
            end else begin
                state_nxt = misaligned ? HALTED : FETCH;
            end
        end else begin
            case (state)
                FETCH: begin
                    if (halt_take) begin
                        instr_nxt = NOP_INSTR;
                        valid_nxt = 1'b0;
                        if (imem_done) begin
                            state_nxt = HALTED;
                        end else begin
                            state_nxt      = DRAIN;
                            drain_addr_nxt = pc;
                            drain_halt_nxt = 1'b1;
                        end
                    end else if (imem_done) begin
                        pc_nxt = pc + 16'd2;
                        if (stall) begin
                            hold_instr_nxt = imem_data;
                            hold_pc_nxt    = pc;
                            state_nxt      = HOLD;
                        end else begin
                            instr_nxt    = imem_data;
                            curr_pc_nxt  = pc;
                            new_addr_nxt = pc + 16'd2;
                            valid_nxt    = 1'b1;
                        end
                    end else if (!stall) begin
                        // Decode consumed the current word and nothing new arrived: keep the fields, drop valid.
                        valid_nxt = 1'b0;
                    end
                end
                HOLD: begin
                    if (halt_take) begin
                        instr_nxt = NOP_INSTR;
                        valid_nxt = 1'b0;
                        state_nxt = HALTED;
                    end else if (!stall) begin
                        instr_nxt    = hold_instr;
                        curr_pc_nxt  = hold_pc;
                        new_addr_nxt = hold_pc + 16'd2;
                        valid_nxt    = 1'b1;
                        state_nxt    = FETCH;
                    end
                end
                DRAIN: begin
                    if (imem_done) state_nxt = drain_halt ? HALTED : FETCH;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            drain_addr  <= RESET_PC;
            drain_halt  <= 1'b0;
            hold_instr  <= NOP_INSTR;
            hold_pc     <= RESET_PC;
            instruction <= NOP_INSTR;
            currPC      <= RESET_PC;
            new_addr    <= RESET_PC + 16'd2;
            valid_id    <= 1'b0;
            err         <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register samples the pre-edge values.
            state       <= state_nxt;
            pc          <= pc_nxt;
            drain_addr  <= drain_addr_nxt;
            drain_halt  <= drain_halt_nxt;
            hold_instr  <= hold_instr_nxt;
            hold_pc     <= hold_pc_nxt;
            instruction <= instr_nxt;
            currPC      <= curr_pc_nxt;
            new_addr    <= new_addr_nxt;
            valid_id    <= valid_nxt;
            err         <= err_nxt;
        end
    end

endmodule

// File: tb/tb_fetch_ifid.sv
// Scoreboard bench for fetch_ifid: random stall/flush/latency against a program-order model of the fetch stream.
module tb_fetch_ifid;

    localparam logic [15:0] RESET_PC  = 16'h0000;
    localparam logic [15:0] NOP_INSTR = 16'h0800;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0, flush = 1'b0, halt_dec = 1'b0;
    logic [15:0] nextPC = '0;
    logic [15:0] imem_data = '0;
    logic        imem_done = 1'b0;
    logic        imem_rd, valid_id, fetch_busy, err;
    logic [15:0] imem_addr, instruction, currPC, new_addr;

    fetch_ifid #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .nextPC(nextPC),
        .halt_dec(halt_dec), .imem_data(imem_data), .imem_done(imem_done),
        .imem_rd(imem_rd), .imem_addr(imem_addr), .instruction(instruction),
        .currPC(currPC), .new_addr(new_addr), .valid_id(valid_id),
        .fetch_busy(fetch_busy), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Memory contents and the expected program-order stream of IF/ID words.
    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc;
    } exp_t;

    logic [15:0] mem_tbl [256];
    exp_t        exp_q[$];
    logic [15:0] push_pc = '0;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return mem_tbl[a[8:1]];
    endfunction

    task automatic top_up();
        exp_t e;
        while (exp_q.size() < 16) begin
            e.instr = mem_word(push_pc);
            e.pc    = push_pc;
            exp_q.push_back(e);
            push_pc = push_pc + 16'd2;
        end
    endtask

    task automatic restart_stream(input logic [15:0] start);
        exp_q.delete();
        push_pc = start;
        top_up();
    endtask

    // Memory responder: random or fixed extra latency per request, checks address stability.
    int          mem_max_lat = 0;
    bit          mem_fixed = 1'b1;
    int          wait_cnt = 0;
    int          lat = 0;
    logic [15:0] pend_addr = '0;

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (imem_rd) begin
                if (wait_cnt == 0) begin
                    pend_addr = imem_addr;
                    lat = mem_fixed ? mem_max_lat : int'($urandom_range(mem_max_lat, 0));
                end else begin
                    check("imem_addr_stable", imem_addr, pend_addr);
                end
                if (wait_cnt == lat) begin
                    imem_done = 1'b1;
                    imem_data = mem_word(imem_addr);
                    wait_cnt  = 0;
                end else begin
                    imem_done = 1'b0;
                    imem_data = 16'($urandom);
                    wait_cnt++;
                end
            end else begin
                imem_done = 1'b0;
                wait_cnt  = 0;
            end
        end
    end

    // Monitor: checks the effect of the previous edge, then pops on each decode consumption.
    bit          halted_exp = 1'b0, err_model = 1'b0;
    bit          prev_stall = 1'b0, prev_flush = 1'b0, prev_halted = 1'b0;
    bit          prev_halt_take = 1'b0, prev_mis = 1'b0;
    bit          rd_dropped = 1'b0, consume;
    int          drain_cnt = 0;
    int          consume_cnt = 0;
    logic [15:0] prev_next = '0, halt_addr = '0, exp_new;
    logic [15:0] snap_instr = '0, snap_pc = '0, snap_new = '0;
    logic        snap_valid = 1'b0;
    exp_t        e_mon;

    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (!rst) begin
                halted_exp = 1'b0; err_model = 1'b0; prev_stall = 1'b0; prev_flush = 1'b0;
                prev_halted = 1'b0; prev_halt_take = 1'b0; prev_mis = 1'b0;
                rd_dropped = 1'b0; drain_cnt = 0;
            end else begin
                if (prev_mis) err_model = 1'b1;
                check("err", err, err_model);
                check("fetch_busy", fetch_busy, imem_rd & ~imem_done);
                if (prev_halted) begin
                    check("halted_instr", instruction, snap_instr);
                    check("halted_pc", currPC, snap_pc);
                    check("halted_new_addr", new_addr, snap_new);
                    check("halted_valid", valid_id, snap_valid);
                    if (rd_dropped) begin
                        check("halted_rd", imem_rd, 1'b0);
                        check("halted_fetch_pc", imem_addr, halt_addr);
                    end else if (!imem_rd) begin
                        rd_dropped = 1'b1;
                        halt_addr  = imem_addr;
                    end else begin
                        drain_cnt++;
                        if (drain_cnt == 8) check("halt_drain_timeout", imem_rd, 1'b0);
                    end
                end else if (prev_flush) begin
                    exp_new = prev_next + 16'd2;
                    check("flush_instr", instruction, NOP_INSTR);
                    check("flush_pc", currPC, prev_next);
                    check("flush_new_addr", new_addr, exp_new);
                    check("flush_valid", valid_id, 1'b0);
                end else if (prev_halt_take) begin
                    check("halt_instr", instruction, NOP_INSTR);
                    check("halt_valid", valid_id, 1'b0);
                end else if (prev_stall) begin
                    check("stall_instr", instruction, snap_instr);
                    check("stall_pc", currPC, snap_pc);
                    check("stall_new_addr", new_addr, snap_new);
                    check("stall_valid", valid_id, snap_valid);
                end

                prev_halted = halted_exp;
                consume = valid_id & ~stall & ~flush & ~halted_exp;
                if (consume) begin
                    consume_cnt++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL sb_underflow: got pc %h, expected no instruction", currPC);
                    end else begin
                        e_mon   = exp_q.pop_front();
                        exp_new = e_mon.pc + 16'd2;
                        check("id_instr", instruction, e_mon.instr);
                        check("id_pc", currPC, e_mon.pc);
                        check("id_new_addr", new_addr, exp_new);
                    end
                end
                prev_halt_take = consume & halt_dec;
                prev_mis       = flush & ~halted_exp & nextPC[0];
                prev_flush     = flush & ~halted_exp;
                prev_next      = nextPC;
                prev_stall     = stall;
                if (prev_halt_take | prev_mis) halted_exp = 1'b1;
                snap_instr = instruction;
                snap_pc    = currPC;
                snap_new   = new_addr;
                snap_valid = valid_id;
            end
        end
    end

    task automatic do_reset(input int max_lat, input bit fixed);
        @(negedge clk);
        #1;
        rst = 1'b0; stall = 1'b0; flush = 1'b0; halt_dec = 1'b0;
        mem_max_lat = max_lat;
        mem_fixed   = fixed;
        restart_stream(RESET_PC);
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b1;
        consume_cnt = 0;
    endtask

    task automatic drive_cycle(input int stall_pct, input int flush_pct);
        logic [15:0] t;
        @(negedge clk);
        #1;
        halt_dec = 1'b0;
        stall = ($urandom_range(99, 0) < stall_pct);
        flush = ($urandom_range(99, 0) < flush_pct);
        t = 16'($urandom);
        t[0] = 1'b0;
        if ($urandom_range(3, 0) == 0) t = 16'hFFF8 | (t & 16'h0006);
        nextPC = t;
        if (flush) restart_stream(t);
        else top_up();
    endtask

    task automatic flush_to(input logic [15:0] target);
        @(negedge clk);
        #1;
        stall = 1'b0; flush = 1'b1; halt_dec = 1'b0; nextPC = target;
        restart_stream(target);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 256; i++) mem_tbl[i] = 16'($urandom);
        restart_stream(RESET_PC);
        #2 rst = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        check("rst_instr", instruction, NOP_INSTR);
        check("rst_pc", currPC, RESET_PC);
        check("rst_new_addr", new_addr, RESET_PC + 16'd2);
        check("rst_valid", valid_id, 1'b0);
        check("rst_rd", imem_rd, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_busy", fetch_busy, 1'b0);

        // Single-cycle memory: one instruction per cycle from the first edge.
        @(negedge clk);
        #1;
        rst = 1'b1;
        consume_cnt = 0;
        #1;
        check("first_rd", imem_rd, 1'b1);
        check("first_addr", imem_addr, RESET_PC);
        repeat (20) drive_cycle(0, 0);
        #3;
        check("throughput_lat0", consume_cnt, 20);

        // Three-cycle memory: one instruction every third cycle, no duplicates.
        do_reset(2, 1'b1);
        repeat (30) drive_cycle(0, 0);
        #3;
        check("throughput_lat3", consume_cnt, 10);

        // Heavy stall with random latency.
        do_reset(2, 1'b0);
        repeat (150) drive_cycle(40, 0);

        // Stalls and redirects with random latency.
        do_reset(3, 1'b0);
        repeat (300) drive_cycle(25, 10);

        // PC wrap across 16'hFFFE.
        do_reset(1, 1'b0);
        repeat (5) drive_cycle(0, 0);
        flush_to(16'hFFFC);
        repeat (20) drive_cycle(20, 0);

        // HALT: drain, freeze, ignore inputs, then restart from reset.
        do_reset(2, 1'b0);
        repeat (30) drive_cycle(25, 10);
        n = 0;
        while (!halted_exp && n < 60) begin
            @(negedge clk);
            #1;
            stall = 1'b0; flush = 1'b0; halt_dec = 1'b1;
            top_up();
            n++;
        end
        check("halt_taken", halted_exp, 1'b1);
        repeat (15) drive_cycle(30, 20);
        check("halt_rd_dropped", rd_dropped, 1'b1);
        do_reset(0, 1'b1);
        #1;
        check("restart_rd", imem_rd, 1'b1);
        check("restart_addr", imem_addr, RESET_PC);
        repeat (10) drive_cycle(0, 0);

        // Misaligned redirect: sticky error and halt.
        do_reset(3, 1'b0);
        repeat (20) drive_cycle(20, 0);
        flush_to(16'h0033);
        repeat (15) drive_cycle(30, 20);
        #2;
        check("misaligned_err", err, 1'b1);
        check("misaligned_halted", imem_rd, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
